tag_match_pipe: RTL and testbench
=================================

Name: tag_match_pipe

Overview:
- Parametrised, pipelined N-way tag comparator for the L2 lookup path.
- Per request, compares one address tag against WAYS stored tags, qualified by per-way valid bits, and returns hit, hit-way index and a multi-hit error flag.
- Valid/ready handshake on both sides, with full backpressure support.
- Saturating hit/miss statistics counters.
- Sits between the set-array read and the cache controller FSM.

Parameters:
- TAG_BITS, 12, width of each tag.
- WAYS, 4, number of ways compared per request (legal range 1..16).
- WAY_IDX, derived: max(1, $clog2(WAYS)); width of way index. Not user-overridable.
- CNT_BITS, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_tag  in  TAG_BITS  address tag.
- req_way_tags  in  WAYS*TAG_BITS  stored tags; way i occupies bits [i*TAG_BITS +: TAG_BITS].
- req_way_valid  in  WAYS  per-way valid bits.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer accepts result.
- resp_hit  out  1  at least one valid way matched.
- resp_way  out  WAY_IDX  lowest-index matching way; 0 on miss.
- resp_multi_hit  out  1  two or more valid ways matched (coherence error).
- clr_counts  in  1  synchronous clear of both counters.
- hit_count  out  CNT_BITS  completed hit responses, saturating.
- miss_count  out  CNT_BITS  completed miss responses, saturating.

Behaviour:
- Reset (rst_n low, async):
  - s1_valid=0, resp_valid=0, resp_hit=0, resp_way=0, resp_multi_hit=0, hit_count=0, miss_count=0.
  - req_ready reads 1 while in reset and immediately after release.
- Stage 1 (capture):
  - On req_valid && req_ready, register req_tag, req_way_tags and req_way_valid; set s1_valid=1.
  - No combinational path from request inputs to any response output.
- Stage 2 (compare/result):
  - match[i] = req_way_valid[i] && (tag_i == captured tag), computed from stage-1 registers.
  - Result registers load when s1_valid && (!resp_valid || resp_ready).
  - Loaded values: resp_hit = |match; resp_way = lowest i with match[i] (0 if none); resp_multi_hit = popcount(match) >= 2.
- Handshake:
  - req_ready = !s1_valid || (!resp_valid || resp_ready). This combinational path from resp_ready to req_ready is permitted.
  - Stage 1 clears when it advances and no new request arrives in the same cycle. A simultaneous advance and new accept keeps s1_valid=1.
  - resp_valid clears on resp_ready when no new result loads in the same cycle.
  - Latency: accept in cycle N gives resp_valid in cycle N+2.
  - Throughput: 1 request/cycle while resp_ready=1.
  - While resp_valid && !resp_ready, all resp_* outputs hold stable, and stage 1 holds its contents.
  - Maximum occupancy is 2 in flight; a third request sees req_ready=0.
- Invalid ways never match, even if tag bits are equal. All-invalid ways gives a miss.
- WAYS=1: resp_way is constant 0 and resp_multi_hit is constant 0.
- Counters:
  - Increment only on resp_valid && resp_ready: hit_count if resp_hit, else miss_count.
  - A multi-hit counts as one hit.
  - Saturate at 2^CNT_BITS-1; no wrap.
  - clr_counts has priority: it clears both counters and discards any increment in the same cycle.
- Reset mid-operation: in-flight requests are dropped and no response is produced for them. Counters return to 0.
- Debug $display: simulation-only, behind `ifndef SYNTHESIS.

Test Plan:
- Single hit: WAYS=4, req_tag=0xABC, tags={0x111,0xABC,0x222,0x333}, valid=4'b1111, resp_ready=1 -> two cycles after accept: resp_hit=1, resp_way=1, resp_multi_hit=0, hit_count=1.
- Invalid and miss: tag 0xABC present only in way 2 with valid[2]=0 -> resp_hit=0, resp_way=0, miss_count=1. Repeat with valid[2]=1 -> hit, way=2.
- Multi-hit: ways 1 and 3 both hold 0x5A5, both valid -> resp_hit=1, resp_way=1, resp_multi_hit=1, hit_count increments by 1.
- Backpressure: stream 4 requests with resp_ready=0 -> exactly 2 accepted, req_ready=0 afterwards, response held stable for 5 cycles. Then raise resp_ready -> remaining requests drain in order at 1/cycle, counters total 4.
- Saturation and clear: CNT_BITS=2, 5 hits -> hit_count sticks at 3. Assert clr_counts in the same cycle as a response handshake -> both counters read 0 next cycle.
- Async reset: assert rst_n=0 between clock edges with 2 requests in flight -> resp_valid=0 and counters=0 immediately. After release, req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/tag_match_pipe.sv
// tag_match_pipe: two-stage N-way tag comparator for the L2 lookup path.
//
// Stage 1 registers one request (tag, stored way tags, way valid bits).
// Stage 2 compares the captured tag against every valid way and registers
// hit, lowest matching way index and a multi-hit flag. Both stages use a
// valid/ready handshake with full backpressure. Saturating hit/miss counters
// count completed responses.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_tag           address tag to look up
//   req_way_tags      stored tags, way i at [i*TAG_BITS +: TAG_BITS]
//   req_way_valid     per-way valid bits
//   resp_valid/ready  response handshake
//   resp_hit          at least one valid way matched
//   resp_way          lowest matching way (0 on miss)
//   resp_multi_hit    two or more valid ways matched
//   clr_counts        synchronous clear of both counters (wins over increment)
//   hit_count         saturating count of completed hit responses
//   miss_count        saturating count of completed miss responses
module tag_match_pipe #(
  parameter int unsigned TAG_BITS = 12,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned CNT_BITS = 16,
  localparam int unsigned WAY_IDX = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TAG_BITS-1:0]      req_tag,
  input  logic [WAYS*TAG_BITS-1:0] req_way_tags,
  input  logic [WAYS-1:0]          req_way_valid,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic [WAY_IDX-1:0]       resp_way,
  output logic                     resp_multi_hit,
  input  logic                     clr_counts,
  output logic [CNT_BITS-1:0]      hit_count,
  output logic [CNT_BITS-1:0]      miss_count
);

  // Stage 1 state
  logic                     s1_valid_q, s1_valid_d;
  logic [TAG_BITS-1:0]      s1_tag_q;
  logic [WAYS*TAG_BITS-1:0] s1_way_tags_q;
  logic [WAYS-1:0]          s1_way_valid_q;

  // Stage 2 state
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_hit_q, resp_hit_d;
  logic [WAY_IDX-1:0]       resp_way_q, resp_way_d;
  logic                     resp_multi_q, resp_multi_d;

  // Counters
  logic [CNT_BITS-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_BITS-1:0]      miss_cnt_q, miss_cnt_d;

  logic                     out_free;
  logic                     s1_adv;
  logic                     accept;
  logic                     resp_fire;

  // Output register can take a new result when empty or being drained.
  assign out_free  = !resp_valid_q || resp_ready;
  assign s1_adv    = s1_valid_q && out_free;
  assign req_ready = !s1_valid_q || out_free;
  assign accept    = req_valid && req_ready;
  assign resp_fire = resp_valid_q && resp_ready;

  // Stage 1 occupancy: a new accept refills the slot even as it advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_tag_q       <= '0;
      s1_way_tags_q  <= '0;
      s1_way_valid_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_tag_q       <= req_tag;
        s1_way_tags_q  <= req_way_tags;
        s1_way_valid_q <= req_way_valid;
      end
    end
  end

  // Stage 2 compare: scanning upward, the first match sets the index and any
  // later match marks a multi-hit. With WAYS=1 neither the index nor the
  // multi-hit flag can ever leave 0.
  always_comb begin
    logic               found;
    logic               multi;
    logic [WAY_IDX-1:0] idx;
    found = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (s1_way_valid_q[i] && (s1_way_tags_q[i*TAG_BITS +: TAG_BITS] == s1_tag_q)) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found = 1'b1;
          idx   = WAY_IDX'(i);
        end
      end
    end

    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    resp_multi_d = resp_multi_q;
    if (s1_adv) begin
      resp_valid_d = 1'b1;
      resp_hit_d   = found;
      resp_way_d   = idx;
      resp_multi_d = multi;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_multi_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      resp_multi_q <= resp_multi_d;
    end
  end

  // Statistics: clear wins over a same-cycle increment; counts stick at max.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (clr_counts) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (resp_fire) begin
      if (resp_hit_q) begin
        if (hit_cnt_q != '1) begin
          hit_cnt_d = hit_cnt_q + CNT_BITS'(1);
        end
      end else begin
        if (miss_cnt_q != '1) begin
          miss_cnt_d = miss_cnt_q + CNT_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_hit       = resp_hit_q;
  assign resp_way       = resp_way_q;
  assign resp_multi_hit = resp_multi_q;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_tag_match_pipe.sv
// Testbench for tag_match_pipe (TAG_BITS=12, WAYS=4, CNT_BITS=2).
// Accepted requests push a model result into a queue; completed responses pop
// and compare. Counters are tracked by a saturating model every cycle.
module tb_tag_match_pipe;

  localparam int unsigned TB_TAG  = 12;
  localparam int unsigned TB_WAYS = 4;
  localparam int unsigned TB_CNT  = 2;
  localparam int          CNT_MAX = (1 << TB_CNT) - 1;

  typedef struct packed {
    logic       hit;
    logic [1:0] way;
    logic       multi;
  } exp_t;

  logic                         clk;
  logic                         rst_n;
  logic                         req_valid;
  logic                         req_ready;
  logic [TB_TAG-1:0]            req_tag;
  logic [TB_WAYS*TB_TAG-1:0]    req_way_tags;
  logic [TB_WAYS-1:0]           req_way_valid;
  logic                         resp_valid;
  logic                         resp_ready;
  logic                         resp_hit;
  logic [1:0]                   resp_way;
  logic                         resp_multi_hit;
  logic                         clr_counts;
  logic [TB_CNT-1:0]            hit_count;
  logic [TB_CNT-1:0]            miss_count;

  tag_match_pipe #(
    .TAG_BITS (TB_TAG),
    .WAYS     (TB_WAYS),
    .CNT_BITS (TB_CNT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_tag        (req_tag),
    .req_way_tags   (req_way_tags),
    .req_way_valid  (req_way_valid),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_hit       (resp_hit),
    .resp_way       (resp_way),
    .resp_multi_hit (resp_multi_hit),
    .clr_counts     (clr_counts),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   exp_hit  = 0;
  int   exp_miss = 0;
  int   acc_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [TB_TAG-1:0] tag,
                                 input logic [TB_WAYS*TB_TAG-1:0] tags,
                                 input logic [TB_WAYS-1:0] vld);
    exp_t e;
    int   cnt;
    e   = '0;
    cnt = 0;
    for (int i = TB_WAYS - 1; i >= 0; i--) begin
      if (vld[i] && (tags[i*TB_TAG +: TB_TAG] == tag)) begin
        e.way = 2'(i);
        cnt++;
      end
    end
    e.hit   = (cnt > 0);
    e.multi = (cnt > 1);
    return e;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  exp_t mon_e;
  logic mon_fired;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("hit_cnt",  32'(hit_count),  32'(exp_hit));
      chk("miss_cnt", 32'(miss_count), 32'(exp_miss));
      mon_fired = 1'b0;
      mon_e     = '0;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("stale_resp", 32'(resp_valid), 32'd0);
        end else if (resp_ready) begin
          mon_e = sb.pop_front();
          chk("resp_hit",   32'(resp_hit),       32'(mon_e.hit));
          chk("resp_way",   32'(resp_way),       32'(mon_e.way));
          chk("resp_multi", 32'(resp_multi_hit), 32'(mon_e.multi));
          mon_fired = 1'b1;
        end
      end
      if (clr_counts) begin
        exp_hit  = 0;
        exp_miss = 0;
      end else if (mon_fired) begin
        if (mon_e.hit) begin
          if (exp_hit != CNT_MAX) exp_hit++;
        end else begin
          if (exp_miss != CNT_MAX) exp_miss++;
        end
      end
      if (req_valid && req_ready) begin
        sb.push_back(model(req_tag, req_way_tags, req_way_valid));
        acc_cnt++;
      end
    end
  end

  task automatic drive(input logic [TB_TAG-1:0] tag,
                       input logic [TB_WAYS*TB_TAG-1:0] tags,
                       input logic [TB_WAYS-1:0] vld);
    req_valid     = 1'b1;
    req_tag       = tag;
    req_way_tags  = tags;
    req_way_valid = vld;
  endtask

  // Present a request and hold it until accepted; leaves req_valid high.
  task automatic send(input logic [TB_TAG-1:0] tag,
                      input logic [TB_WAYS*TB_TAG-1:0] tags,
                      input logic [TB_WAYS-1:0] vld);
    logic ok;
    ok = 1'b0;
    drive(tag, tags, vld);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("req_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    idle();
    for (int i = 0; i < 30; i++) begin
      sample();
      if (sb.size() == 0 && !resp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic clear_counts();
    @(posedge clk);
    #1 clr_counts = 1'b1;
    @(posedge clk);
    #1 clr_counts = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_tag       = '0;
    req_way_tags  = '0;
    req_way_valid = '0;
    resp_ready    = 1'b1;
    clr_counts    = 1'b0;

    // Reset state
    #12;
    chk("rst_resp_valid", 32'(resp_valid),     32'd0);
    chk("rst_resp_hit",   32'(resp_hit),       32'd0);
    chk("rst_resp_way",   32'(resp_way),       32'd0);
    chk("rst_resp_multi", 32'(resp_multi_hit), 32'd0);
    chk("rst_hit_cnt",    32'(hit_count),      32'd0);
    chk("rst_miss_cnt",   32'(miss_count),     32'd0);
    chk("rst_req_ready",  32'(req_ready),      32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Single hit in way 1
    send(12'hABC, {12'h333, 12'h222, 12'hABC, 12'h111}, 4'b1111);
    drain();
    // Matching tag in an invalid way misses, then hits once valid
    send(12'hABC, {12'h333, 12'hABC, 12'h222, 12'h111}, 4'b1011);
    send(12'hABC, {12'h333, 12'hABC, 12'h222, 12'h111}, 4'b1111);
    drain();
    // Multi-hit in ways 1 and 3
    send(12'h5A5, {12'h5A5, 12'h222, 12'h5A5, 12'h111}, 4'b1111);
    // All ways invalid with equal tags
    send(12'h111, {12'h111, 12'h111, 12'h111, 12'h111}, 4'b0000);
    // Hit in way 0 and way 3 only
    send(12'h0F0, {12'h0F0, 12'h222, 12'h333, 12'h0F0}, 4'b1001);
    send(12'h0F0, {12'h0F0, 12'h222, 12'h333, 12'h0F0}, 4'b1000);
    drain();

    // Saturation: five back-to-back hits on a 2-bit counter
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      send(12'h100 + 12'(i), {12'h100 + 12'(i), 12'h0, 12'h0, 12'h0}, 4'b1000);
    end
    drain();
    chk("hit_sat", 32'(hit_count), 32'(CNT_MAX));

    // Clear in the same cycle as a response handshake
    send(12'h777, {12'h0, 12'h0, 12'h0, 12'h777}, 4'b0001);
    idle();
    @(posedge clk);
    #1 clr_counts = 1'b1;
    @(posedge clk);
    #1 clr_counts = 1'b0;
    sample();
    chk("clr_hit",  32'(hit_count),  32'd0);
    chk("clr_miss", 32'(miss_count), 32'd0);

    // Backpressure: only two requests fit, outputs hold while stalled
    begin
      int base;
      base = acc_cnt;
      resp_ready = 1'b0;
      send(12'hAAA, {12'h0, 12'hAAA, 12'h0, 12'h0}, 4'b1111);
      send(12'hBBB, {12'h0, 12'h0, 12'h0, 12'h0}, 4'b1111);
      drive(12'hCCC, {12'hCCC, 12'h0, 12'h0, 12'h0}, 4'b1000);
      for (int i = 0; i < 5; i++) begin
        sample();
        chk("bp_req_ready",  32'(req_ready),     32'd0);
        chk("bp_accepted",   32'(acc_cnt - base), 32'd2);
        chk("bp_resp_valid", 32'(resp_valid),    32'd1);
        chk("bp_hold_hit",   32'(resp_hit),      32'(sb[0].hit));
        chk("bp_hold_way",   32'(resp_way),      32'(sb[0].way));
      end
      resp_ready = 1'b1;
      send(12'hCCC, {12'hCCC, 12'h0, 12'h0, 12'h0}, 4'b1000);
      send(12'hDDD, {12'h0, 12'h0, 12'h0, 12'hDDE}, 4'b1111);
      drain();
      chk("bp_total_hit",  32'(hit_count),  32'd2);
      chk("bp_total_miss", 32'(miss_count), 32'd2);
    end

    // Async reset with two requests in flight
    resp_ready = 1'b0;
    send(12'h321, {12'h0, 12'h0, 12'h0, 12'h321}, 4'b0001);
    send(12'h654, {12'h0, 12'h0, 12'h654, 12'h0}, 4'b0010);
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_hit_cnt",    32'(hit_count),  32'd0);
    chk("arst_miss_cnt",   32'(miss_count), 32'd0);
    chk("arst_req_ready",  32'(req_ready),  32'd1);
    sb.delete();
    exp_hit  = 0;
    exp_miss = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("arst_rel_req_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("arst_no_stale", 32'(resp_valid), 32'd0);
    end

    // Post-reset operation resumes normally
    send(12'h9A9, {12'h9A9, 12'h9A9, 12'h0, 12'h0}, 4'b1100);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
